// File: rtl/trap_sequencer.sv
`timescale 1ns/1ps
// trap_sequencer: owns the CSR unit's single access port. It arbitrates the
// port between pipeline CSR instructions and trap entry/mret sequencing.
// Trap entry writes mepc, mcause and mstatus, then redirects fetch to mtvec.
// mret restores mstatus, then redirects fetch to mepc.
// Ports: clk_i/rst_ni (async active-low); pc_i, ecall_i, ebreak_i, mret_i,
//   mstatus_mie_i, mie_i, mip_i event inputs; req_ack_o, busy_o,
//   redirect_valid_o, redirect_pc_o to fetch/pipeline; pipe_csr_* is the
//   pipeline-side CSR port; csr_* and csr_rdata_i connect to the CSR unit.
module trap_sequencer #(
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MTVEC   = 12'h305
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        mstatus_mie_i,
    input  logic [2:0]  mie_i,
    input  logic [2:0]  mip_i,
    output logic        req_ack_o,
    output logic        busy_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic [11:0] pipe_csr_addr_i,
    input  logic [31:0] pipe_csr_data_i,
    input  logic [1:0]  pipe_csr_op_i,
    input  logic        pipe_csr_we_i,
    output logic        pipe_csr_gnt_o,
    output logic [31:0] pipe_csr_rdata_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_data_o,
    output logic [1:0]  csr_op_o,
    output logic        csr_we_o,
    input  logic [31:0] csr_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        JUMP,
        R_STATUS,
        R_JUMP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic [31:0] cause_d;
    logic [31:0] rpc_q;
    logic        take;
    logic        is_mret;
    logic [2:0]  irq;
    logic [31:0] base;

    // bit 2 = external, bit 1 = timer, bit 0 = software
    assign irq  = mstatus_mie_i ? (mie_i & mip_i) : 3'b000;
    assign base = {csr_rdata_i[31:2], 2'b00};

    always_comb begin
        take    = 1'b0;
        is_mret = 1'b0;
        cause_d = cause_q;
        if (state_q == IDLE) begin
            if (ecall_i) begin
                take    = 1'b1;
                cause_d = 32'd11;
            end else if (ebreak_i) begin
                take    = 1'b1;
                cause_d = 32'd3;
            end else if (irq[2]) begin
                take    = 1'b1;
                cause_d = 32'h8000000B;
            end else if (irq[0]) begin
                take    = 1'b1;
                cause_d = 32'h80000003;
            end else if (irq[1]) begin
                take    = 1'b1;
                cause_d = 32'h80000007;
            end else if (mret_i) begin
                take    = 1'b1;
                is_mret = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ack_o        = take & rst_ni;
        busy_o           = (state_q != IDLE);
        pipe_csr_gnt_o   = (state_q == IDLE) & ~take & rst_ni;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = rpc_q;
        csr_addr_o       = 12'h000;
        csr_data_o       = 32'h0;
        csr_op_o         = 2'b00;
        csr_we_o         = 1'b0;
        pipe_csr_rdata_o = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = is_mret ? R_STATUS : W_EPC;
                end else if (pipe_csr_gnt_o) begin
                    csr_addr_o       = pipe_csr_addr_i;
                    csr_data_o       = pipe_csr_data_i;
                    csr_op_o         = pipe_csr_op_i;
                    csr_we_o         = pipe_csr_we_i;
                    pipe_csr_rdata_o = csr_rdata_i;
                end
            end
            W_EPC: begin
                state_d    = W_CAUSE;
                csr_addr_o = CSR_MEPC;
                csr_data_o = {pc_q[31:2], 2'b00};
                csr_we_o   = 1'b1;
            end
            W_CAUSE: begin
                state_d    = W_STATUS;
                csr_addr_o = CSR_MCAUSE;
                csr_data_o = cause_q;
                csr_we_o   = 1'b1;
            end
            W_STATUS: begin
                // MPIE <= MIE, MIE <= 0, using the same-cycle read
                state_d       = JUMP;
                csr_addr_o    = CSR_MSTATUS;
                csr_data_o    = csr_rdata_i;
                csr_data_o[7] = csr_rdata_i[3];
                csr_data_o[3] = 1'b0;
                csr_we_o      = 1'b1;
            end
            JUMP: begin
                state_d          = IDLE;
                csr_addr_o       = CSR_MTVEC;
                redirect_valid_o = 1'b1;
                if (csr_rdata_i[1:0] == 2'b01 && cause_q[31]) begin
                    redirect_pc_o = base + {25'd0, cause_q[4:0], 2'b00};
                end else begin
                    redirect_pc_o = base;
                end
            end
            R_STATUS: begin
                // MIE <= MPIE, MPIE <= 1
                state_d       = R_JUMP;
                csr_addr_o    = CSR_MSTATUS;
                csr_data_o    = csr_rdata_i;
                csr_data_o[3] = csr_rdata_i[7];
                csr_data_o[7] = 1'b1;
                csr_we_o      = 1'b1;
            end
            R_JUMP: begin
                state_d          = IDLE;
                csr_addr_o       = CSR_MEPC;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = base;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
            rpc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (take) begin
                pc_q    <= pc_i;
                cause_q <= cause_d;
            end
            if (redirect_valid_o) begin
                rpc_q <= redirect_pc_o;
            end
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
`timescale 1ns/1ps
// tb_trap_sequencer: directed scenarios against trap_sequencer with a
// small behavioural CSR unit (combinational read, posedge write).
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        ecall_i = 1'b0;
    logic        ebreak_i = 1'b0;
    logic        mret_i = 1'b0;
    logic        mstatus_mie_i = 1'b0;
    logic [2:0]  mie_i = 3'b000;
    logic [2:0]  mip_i = 3'b000;
    logic        req_ack_o;
    logic        busy_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [11:0] pipe_csr_addr_i = 12'h0;
    logic [31:0] pipe_csr_data_i = 32'h0;
    logic [1:0]  pipe_csr_op_i = 2'b00;
    logic        pipe_csr_we_i = 1'b0;
    logic        pipe_csr_gnt_o;
    logic [31:0] pipe_csr_rdata_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_data_o;
    logic [1:0]  csr_op_o;
    logic        csr_we_o;
    logic [31:0] csr_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_epc, m_cause, m_status, m_tvec;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .pc_i             (pc_i),
        .ecall_i          (ecall_i),
        .ebreak_i         (ebreak_i),
        .mret_i           (mret_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .mie_i            (mie_i),
        .mip_i            (mip_i),
        .req_ack_o        (req_ack_o),
        .busy_o           (busy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .pipe_csr_addr_i  (pipe_csr_addr_i),
        .pipe_csr_data_i  (pipe_csr_data_i),
        .pipe_csr_op_i    (pipe_csr_op_i),
        .pipe_csr_we_i    (pipe_csr_we_i),
        .pipe_csr_gnt_o   (pipe_csr_gnt_o),
        .pipe_csr_rdata_o (pipe_csr_rdata_o),
        .csr_addr_o       (csr_addr_o),
        .csr_data_o       (csr_data_o),
        .csr_op_o         (csr_op_o),
        .csr_we_o         (csr_we_o),
        .csr_rdata_i      (csr_rdata_i)
    );

    // CSR unit model: op 00/11 write, 01 set, 10 clear
    function automatic logic [31:0] csr_apply(
        input logic [31:0] old, input logic [31:0] d, input logic [1:0] op);
        case (op)
            2'b01:   return old | d;
            2'b10:   return old & ~d;
            default: return d;
        endcase
    endfunction

    always_comb begin
        case (csr_addr_o)
            12'h341: csr_rdata_i = m_epc;
            12'h342: csr_rdata_i = m_cause;
            12'h300: csr_rdata_i = m_status;
            12'h305: csr_rdata_i = m_tvec;
            default: csr_rdata_i = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_we_o) begin
            case (csr_addr_o)
                12'h341: m_epc    <= csr_apply(m_epc, csr_data_o, csr_op_o);
                12'h342: m_cause  <= csr_apply(m_cause, csr_data_o, csr_op_o);
                12'h300: m_status <= csr_apply(m_status, csr_data_o, csr_op_o);
                12'h305: m_tvec   <= csr_apply(m_tvec, csr_data_o, csr_op_o);
                default: ;
            endcase
        end
    end

    task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pipe_csr_addr_i = a;
        pipe_csr_data_i = d;
        pipe_csr_op_i   = 2'b00;
        pipe_csr_we_i   = 1'b1;
        @(negedge clk);
        pipe_csr_we_i   = 1'b0;
    endtask

    task automatic test_reset;
        pipe_csr_we_i = 1'b1;
        pipe_csr_addr_i = 12'h300;
        #12;
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++;
            $display("FAIL rst_busy got %b want 0", busy_o); end
        n_cmp++; if (pipe_csr_gnt_o !== 1'b0) begin n_bad++;
            $display("FAIL rst_gnt got %b want 0", pipe_csr_gnt_o); end
        n_cmp++; if (csr_we_o !== 1'b0 || csr_op_o !== 2'b00) begin n_bad++;
            $display("FAIL rst_we_op got %b/%b want 0/00", csr_we_o, csr_op_o); end
        n_cmp++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_redir got %b/%h want 0/0",
                     redirect_valid_o, redirect_pc_o); end
        n_cmp++; if (req_ack_o !== 1'b0) begin n_bad++;
            $display("FAIL rst_ack got %b want 0", req_ack_o); end
        pipe_csr_we_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_pipe;
        @(negedge clk);
        pipe_csr_addr_i = 12'h300;
        pipe_csr_data_i = 32'h8;
        pipe_csr_op_i   = 2'b00;
        pipe_csr_we_i   = 1'b1;
        #1;
        n_cmp++; if (pipe_csr_gnt_o !== 1'b1 || csr_we_o !== 1'b1) begin n_bad++;
            $display("FAIL pipe_wr gnt/we got %b/%b want 1/1",
                     pipe_csr_gnt_o, csr_we_o); end
        n_cmp++; if (csr_addr_o !== 12'h300 || csr_data_o !== 32'h8) begin
            n_bad++;
            $display("FAIL pipe_wr addr/data got %h/%h want 300/8",
                     csr_addr_o, csr_data_o); end
        @(negedge clk);
        pipe_csr_we_i = 1'b0;
        #1;
        n_cmp++; if (pipe_csr_gnt_o !== 1'b1 || csr_we_o !== 1'b0) begin n_bad++;
            $display("FAIL pipe_rd gnt/we got %b/%b want 1/0",
                     pipe_csr_gnt_o, csr_we_o); end
        n_cmp++; if (pipe_csr_rdata_o !== 32'h8) begin n_bad++;
            $display("FAIL pipe_rdata got %h want 8", pipe_csr_rdata_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++;
            $display("FAIL pipe_busy got %b want 0", busy_o); end
        pipe_write(12'h305, 32'h200);
        n_cmp++; if (m_tvec !== 32'h200) begin n_bad++;
            $display("FAIL pipe_mtvec got %h want 200", m_tvec); end
    endtask

    task automatic test_ecall;
        @(negedge clk);
        pc_i    = 32'h100;
        ecall_i = 1'b1;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1 || pipe_csr_gnt_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ecall_ack ack/gnt got %b/%b want 1/0",
                     req_ack_o, pipe_csr_gnt_o); end
        @(negedge clk);
        ecall_i = 1'b0;
        pipe_csr_we_i   = 1'b1;
        pipe_csr_addr_i = 12'h305;
        pipe_csr_data_i = 32'hDEAD;
        #1;
        n_cmp++; if (csr_addr_o !== 12'h341 || csr_data_o !== 32'h100 ||
                     csr_we_o !== 1'b1) begin n_bad++;
            $display("FAIL ecall_wepc got %h/%h/%b want 341/100/1",
                     csr_addr_o, csr_data_o, csr_we_o); end
        n_cmp++; if (pipe_csr_gnt_o !== 1'b0 || busy_o !== 1'b1 ||
                     redirect_valid_o !== 1'b0 || req_ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ecall_c1 gnt/busy/rv/ack got %b%b%b%b want 0100",
                     pipe_csr_gnt_o, busy_o, redirect_valid_o, req_ack_o); end
        @(negedge clk);
        pipe_csr_we_i = 1'b0;
        #1;
        n_cmp++; if (csr_addr_o !== 12'h342 || csr_data_o !== 32'd11) begin
            n_bad++;
            $display("FAIL ecall_wcause got %h/%h want 342/b",
                     csr_addr_o, csr_data_o); end
        @(negedge clk); #1;
        n_cmp++; if (csr_addr_o !== 12'h300 || csr_data_o !== 32'h80 ||
                     redirect_valid_o !== 1'b0) begin n_bad++;
            $display("FAIL ecall_wstatus got %h/%h/%b want 300/80/0",
                     csr_addr_o, csr_data_o, redirect_valid_o); end
        @(negedge clk); #1;
        n_cmp++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h200 ||
                     pipe_csr_gnt_o !== 1'b0) begin n_bad++;
            $display("FAIL ecall_jump rv/pc/gnt got %b/%h/%b want 1/200/0",
                     redirect_valid_o, redirect_pc_o, pipe_csr_gnt_o); end
        n_cmp++; if (m_epc !== 32'h100 || m_cause !== 32'd11 ||
                     m_status !== 32'h80 || m_tvec !== 32'h200) begin n_bad++;
            $display("FAIL ecall_csrs got %h/%h/%h/%h want 100/b/80/200",
                     m_epc, m_cause, m_status, m_tvec); end
        @(negedge clk); #1;
        n_cmp++; if (busy_o !== 1'b0 || redirect_valid_o !== 1'b0 ||
                     pipe_csr_gnt_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
            n_bad++;
            $display("FAIL ecall_after busy/rv/gnt/pc got %b/%b/%b/%h want 0/0/1/200",
                     busy_o, redirect_valid_o, pipe_csr_gnt_o, redirect_pc_o); end
    endtask

    task automatic test_mret;
        @(negedge clk);
        mret_i = 1'b1;
        pc_i   = 32'h0;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1) begin n_bad++;
            $display("FAIL mret_ack got %b want 1", req_ack_o); end
        @(negedge clk);
        mret_i = 1'b0;
        #1;
        n_cmp++; if (redirect_valid_o !== 1'b0 || csr_addr_o !== 12'h300 ||
                     csr_data_o !== 32'h88 || csr_we_o !== 1'b1) begin n_bad++;
            $display("FAIL mret_rstatus got %b/%h/%h/%b want 0/300/88/1",
                     redirect_valid_o, csr_addr_o, csr_data_o, csr_we_o); end
        @(negedge clk); #1;
        n_cmp++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h100 ||
                     csr_we_o !== 1'b0) begin n_bad++;
            $display("FAIL mret_jump rv/pc/we got %b/%h/%b want 1/100/0",
                     redirect_valid_o, redirect_pc_o, csr_we_o); end
        @(negedge clk); #1;
        n_cmp++; if (m_status !== 32'h88 || busy_o !== 1'b0) begin n_bad++;
            $display("FAIL mret_done status/busy got %h/%b want 88/0",
                     m_status, busy_o); end
    endtask

    task automatic test_irq_vectored;
        pipe_write(12'h305, 32'h201);
        @(negedge clk);
        mstatus_mie_i = 1'b1;
        mie_i = 3'b110;
        mip_i = 3'b110;
        pc_i  = 32'h123;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1) begin n_bad++;
            $display("FAIL irq_ext_ack got %b want 1", req_ack_o); end
        @(negedge clk);
        mip_i = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h22C) begin
            n_bad++;
            $display("FAIL irq_ext_jump rv/pc got %b/%h want 1/22c",
                     redirect_valid_o, redirect_pc_o); end
        n_cmp++; if (m_cause !== 32'h8000000B || m_epc !== 32'h120) begin
            n_bad++;
            $display("FAIL irq_ext_csrs cause/epc got %h/%h want 8000000b/120",
                     m_cause, m_epc); end
        @(negedge clk);
        mie_i = 3'b011;
        mip_i = 3'b011;
        pc_i  = 32'h400;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1) begin n_bad++;
            $display("FAIL irq_sw_ack got %b want 1", req_ack_o); end
        @(negedge clk);
        mip_i = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h20C ||
                     m_cause !== 32'h80000003) begin n_bad++;
            $display("FAIL irq_sw_jump rv/pc/cause got %b/%h/%h want 1/20c/80000003",
                     redirect_valid_o, redirect_pc_o, m_cause); end
        @(negedge clk);
        ebreak_i = 1'b1;
        pc_i     = 32'h500;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1) begin n_bad++;
            $display("FAIL ebreak_ack got %b want 1", req_ack_o); end
        @(negedge clk);
        ebreak_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h200 ||
                     m_cause !== 32'd3) begin n_bad++;
            $display("FAIL ebreak_jump rv/pc/cause got %b/%h/%h want 1/200/3",
                     redirect_valid_o, redirect_pc_o, m_cause); end
    endtask

    task automatic test_priority;
        @(negedge clk);
        ecall_i = 1'b1;
        mstatus_mie_i = 1'b1;
        mie_i = 3'b111;
        mip_i = 3'b111;
        pc_i  = 32'h40;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1) begin n_bad++;
            $display("FAIL prio_ack got %b want 1", req_ack_o); end
        @(negedge clk);
        ecall_i = 1'b0;
        mstatus_mie_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (redirect_pc_o !== 32'h200 || m_cause !== 32'd11) begin
            n_bad++;
            $display("FAIL prio_ecall pc/cause got %h/%h want 200/b",
                     redirect_pc_o, m_cause); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (req_ack_o !== 1'b0 || pipe_csr_gnt_o !== 1'b1) begin
                n_bad++;
                $display("FAIL prio_masked[%0d] ack/gnt got %b/%b want 0/1",
                         i, req_ack_o, pipe_csr_gnt_o); end
        end
        mip_i = 3'b000;
        mie_i = 3'b000;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ecall_i = 1'b1;
        pc_i    = 32'h300;
        #1;
        n_cmp++; if (req_ack_o !== 1'b1) begin n_bad++;
            $display("FAIL rmid_ack got %b want 1", req_ack_o); end
        @(negedge clk);
        ecall_i = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (csr_addr_o !== 12'h342) begin n_bad++;
            $display("FAIL rmid_in_wcause addr got %h want 342", csr_addr_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (busy_o !== 1'b0 || csr_we_o !== 1'b0 ||
                     csr_addr_o !== 12'h0 || pipe_csr_gnt_o !== 1'b0 ||
                     redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
            n_bad++;
            $display("FAIL rmid_async busy/we/addr/gnt/rv/pc got %b/%b/%h/%b/%b/%h",
                     busy_o, csr_we_o, csr_addr_o, pipe_csr_gnt_o,
                     redirect_valid_o, redirect_pc_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (pipe_csr_gnt_o !== 1'b1 || busy_o !== 1'b0 ||
                     m_epc !== 32'h300) begin n_bad++;
            $display("FAIL rmid_release gnt/busy/epc got %b/%b/%h want 1/0/300",
                     pipe_csr_gnt_o, busy_o, m_epc); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (redirect_valid_o !== 1'b0) begin n_bad++;
                $display("FAIL rmid_noredir[%0d] got %b want 0",
                         i, redirect_valid_o); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_ecall();
        test_mret();
        test_irq_vectored();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
